ascon_perm_ctrl: RTL and testbench

ASCON_PERM_CTRL -- requirements
Module: ascon_perm_ctrl

---
 rtl/ascon_pkg.sv | 28 ++
 rtl/ascon_perm_ctrl.sv | 144 ++++++++++++++
 tb/tb_ascon_perm_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ascon_pkg
// Description : Shared types, round counts, FSM encoding and round-constant
//               helper for the ASCON permutation controller.
// Revision    : 1.0 - initial release
// ============================================================================
package ascon_pkg;

    typedef logic [4:0][63:0] ascon_state_t;

    localparam int ROUNDS_A = 12;
    localparam int ROUNDS_B = 8;
    localparam int ROUNDS_C = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } perm_state_e;

    // Constant for round index i: high nibble counts down from 15, low nibble up from 0.
    function automatic logic [7:0] round_const(input logic [3:0] idx);
        return {4'(4'd15 - idx), idx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ascon_perm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ascon_perm_ctrl
// Description : Round sequencer for an ASCON permutation driving an external
//               combinational round datapath; 12/8/6 rounds, abort, interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module ascon_perm_ctrl
    import ascon_pkg::*;
#(
    parameter int IRQ_EN         = 1,
    parameter int DEFAULT_ROUNDS = 12
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic [3:0]   nrounds_i,
    input  ascon_state_t state_i,
    output ascon_state_t round_state_o,
    output logic [7:0]   round_const_o,
    input  ascon_state_t round_state_i,
    output ascon_state_t state_o,
    output logic         busy_o,
    output logic         update_state_o,
    output logic         finished_o,
    output logic         intr_o,
    input  logic         intr_clr_i
);

    localparam logic [3:0] c_last_idx    = 4'd11;
    localparam logic [3:0] c_default_idx = 4'(ROUNDS_A - DEFAULT_ROUNDS);

    perm_state_e  r_state;
    perm_state_e  w_state_next;
    ascon_state_t r_state_q;
    ascon_state_t r_state_out;
    logic [3:0]   r_rc_idx;
    logic [3:0]   w_start_idx;
    logic         w_load;
    logic         w_round;
    logic         w_busy;
    logic         w_finish;

    // Rounds are counted by the constant index, so N rounds start at 12 - N.
    always_comb begin
        w_start_idx = c_default_idx;
        case (nrounds_i)
            4'(ROUNDS_A): w_start_idx = 4'(ROUNDS_A - ROUNDS_A);
            4'(ROUNDS_B): w_start_idx = 4'(ROUNDS_A - ROUNDS_B);
            4'(ROUNDS_C): w_start_idx = 4'(ROUNDS_A - ROUNDS_C);
            default:      w_start_idx = c_default_idx;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_round      = 1'b0;
        w_busy       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_load       = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_busy = 1'b1;
                if (abort_i) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_round = 1'b1;
                    if (r_rc_idx == c_last_idx) begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_busy       = 1'b1;
                w_finish     = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // The final round result goes straight into state_o so it is valid during DONE.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state_q   <= '0;
            r_state_out <= '0;
            r_rc_idx    <= 4'd0;
        end else if (w_load) begin
            r_state_q <= state_i;
            r_rc_idx  <= w_start_idx;
        end else if (w_round) begin
            r_state_q <= round_state_i;
            r_rc_idx  <= r_rc_idx + 4'd1;
            if (r_rc_idx == c_last_idx) begin
                r_state_out <= round_state_i;
            end
        end
    end

    assign round_state_o  = r_state_q;
    assign round_const_o  = (r_state == ST_RUN) ? round_const(r_rc_idx) : 8'h00;
    assign state_o        = r_state_out;
    assign busy_o         = w_busy;
    assign finished_o     = w_finish;
    assign update_state_o = w_finish;

    generate
        if (IRQ_EN != 0) begin : g_intr
            logic r_intr;
            // Set has priority so a clear racing a finish cannot lose the event.
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    r_intr <= 1'b0;
                end else if (w_finish) begin
                    r_intr <= 1'b1;
                end else if (intr_clr_i) begin
                    r_intr <= 1'b0;
                end
            end
            assign intr_o = r_intr;
        end else begin : g_no_intr
            assign intr_o = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ascon_perm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ascon_perm_ctrl
// Description : Self-checking bench; identity-plus-constant round model and a
//               queue of expected round constants / final states.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ascon_perm_ctrl;
    import ascon_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [3:0]   nrounds;
    ascon_state_t state_in;
    ascon_state_t round_state_o;
    logic [7:0]   round_const;
    ascon_state_t round_state_i;
    ascon_state_t state_out;
    logic         busy;
    logic         update_state;
    logic         finished;
    logic         intr;
    logic         intr_clr;

    int n_vec;
    int n_err;

    logic [7:0]   q_rc[$];
    ascon_state_t q_st[$];
    ascon_state_t last_state;
    logic [7:0]   first_rc;
    logic [7:0]   last_rc;

    ascon_perm_ctrl #(.IRQ_EN(1), .DEFAULT_ROUNDS(12)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .start_i        (start),
        .abort_i        (abort),
        .nrounds_i      (nrounds),
        .state_i        (state_in),
        .round_state_o  (round_state_o),
        .round_const_o  (round_const),
        .round_state_i  (round_state_i),
        .state_o        (state_out),
        .busy_o         (busy),
        .update_state_o (update_state),
        .finished_o     (finished),
        .intr_o         (intr),
        .intr_clr_i     (intr_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External round model: XOR the round constant into word 2.
    always_comb begin
        round_state_i    = round_state_o;
        round_state_i[2] = round_state_o[2] ^ {56'd0, round_const};
    end

    function automatic logic [7:0] exp_rc(input int i);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(15 - i);
        lo = 4'(i);
        return {hi, lo};
    endfunction

    function automatic ascon_state_t rand_state();
        ascon_state_t s;
        for (int w = 0; w < 5; w++) s[w] = {$urandom(), $urandom()};
        return s;
    endfunction

    // Entered at a negedge with the DUT idle; leaves at the negedge after DONE.
    task automatic run_perm(input logic [3:0] nr, input int n_exp, input ascon_state_t st,
                            input bit hold, input bit clr_in_done);
        ascon_state_t exp_st;
        logic [7:0]   e;
        exp_st = st;
        for (int k = 0; k < n_exp; k++) begin
            e = exp_rc(12 - n_exp + k);
            q_rc.push_back(e);
            exp_st[2] = exp_st[2] ^ {56'd0, e};
        end
        q_st.push_back(exp_st);
        start    = 1'b1;
        nrounds  = nr;
        state_in = st;
        @(negedge clk);
        if (hold) begin
            nrounds  = 4'd6;
            state_in = rand_state();
        end else begin
            start = 1'b0;
        end
        for (int k = 0; k < n_exp; k++) begin
            e = q_rc.pop_front();
            n_vec++;
            if (round_const !== e || busy !== 1'b1 || finished !== 1'b0) begin
                n_err++;
                $display("FAIL round_const[%0d] nr=%0d: got rc=%h busy=%b fin=%b, want rc=%h busy=1 fin=0",
                         k, nr, round_const, busy, finished, e);
            end
            if (k == 0) first_rc = round_const;
            last_rc = round_const;
            @(negedge clk);
        end
        exp_st = q_st.pop_front();
        n_vec++;
        if (finished !== 1'b1 || update_state !== 1'b1 || busy !== 1'b1 || round_const !== 8'h00) begin
            n_err++;
            $display("FAIL done_cycle nr=%0d: got fin=%b upd=%b busy=%b rc=%h, want 1 1 1 00",
                     nr, finished, update_state, busy, round_const);
        end
        n_vec++;
        if (state_out !== exp_st) begin
            n_err++;
            $display("FAIL state_o nr=%0d: got %h want %h", nr, state_out, exp_st);
        end
        last_state = exp_st;
        if (clr_in_done) intr_clr = 1'b1;
        @(negedge clk);
        intr_clr = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || finished !== 1'b0 || intr !== 1'b1 || state_out !== exp_st) begin
            n_err++;
            $display("FAIL after_done nr=%0d: got busy=%b fin=%b intr=%b, want 0 0 1 (state held)",
                     nr, busy, finished, intr);
        end
    endtask

    task automatic check_all_zero(input string tag);
        n_vec++;
        if (busy !== 1'b0 || finished !== 1'b0 || update_state !== 1'b0 || intr !== 1'b0 ||
            round_const !== 8'h00 || state_out !== '0 || round_state_o !== '0) begin
            n_err++;
            $display("FAIL %s: got busy=%b fin=%b upd=%b intr=%b rc=%h st_nz=%b rs_nz=%b, want all 0",
                     tag, busy, finished, update_state, intr, round_const,
                     |state_out, |round_state_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset_idle");
    endtask

    task automatic test_p12();
        run_perm(4'd12, 12, rand_state(), 1'b0, 1'b0);
        n_vec++;
        if (first_rc !== 8'hF0 || last_rc !== 8'h4B) begin
            n_err++;
            $display("FAIL p12_bounds: got first=%h last=%h, want F0 4B", first_rc, last_rc);
        end
    endtask

    task automatic test_p6();
        run_perm(4'd6, 6, rand_state(), 1'b0, 1'b0);
        n_vec++;
        if (first_rc !== 8'h96 || last_rc !== 8'h4B) begin
            n_err++;
            $display("FAIL p6_bounds: got first=%h last=%h, want 96 4B", first_rc, last_rc);
        end
    endtask

    task automatic test_p8_identity();
        run_perm(4'd8, 8, '0, 1'b0, 1'b0);
        n_vec++;
        if (first_rc !== 8'hB4 || state_out[2] !== 64'h0 || state_out[0] !== 64'h0) begin
            n_err++;
            $display("FAIL p8_identity: got first=%h w2=%h w0=%h, want B4 0 0",
                     first_rc, state_out[2], state_out[0]);
        end
    endtask

    task automatic test_invalid_rounds();
        run_perm(4'd5, 12, rand_state(), 1'b0, 1'b0);
        n_vec++;
        if (first_rc !== 8'hF0) begin
            n_err++;
            $display("FAIL invalid_rounds: got first=%h want F0", first_rc);
        end
    endtask

    task automatic test_back_to_back();
        run_perm(4'd8, 8, rand_state(), 1'b1, 1'b0);
        run_perm(4'd12, 12, rand_state(), 1'b1, 1'b0);
        start = 1'b0;
    endtask

    task automatic test_intr_coincident();
        run_perm(4'd6, 6, rand_state(), 1'b0, 1'b1);
        intr_clr = 1'b1;
        @(negedge clk);
        intr_clr = 1'b0;
        n_vec++;
        if (intr !== 1'b0) begin
            n_err++;
            $display("FAIL intr_clear: got intr=%b want 0", intr);
        end
    endtask

    task automatic test_abort();
        start   = 1'b1;
        nrounds = 4'd12;
        state_in = rand_state();
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || finished !== 1'b0 || update_state !== 1'b0 ||
            intr !== 1'b0 || round_const !== 8'h00) begin
            n_err++;
            $display("FAIL abort: got busy=%b fin=%b upd=%b intr=%b rc=%h, want 0 0 0 0 00",
                     busy, finished, update_state, intr, round_const);
        end
        repeat (14) begin
            @(negedge clk);
            n_vec++;
            if (finished !== 1'b0 || busy !== 1'b0 || state_out !== last_state) begin
                n_err++;
                $display("FAIL abort_quiet: got fin=%b busy=%b state_held=%b, want 0 0 1",
                         finished, busy, state_out === last_state);
            end
        end
        run_perm(4'd12, 12, rand_state(), 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        start    = 1'b1;
        nrounds  = 4'd12;
        state_in = rand_state();
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_run");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (14) begin
            @(negedge clk);
            n_vec++;
            if (finished !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL reset_no_finish: got fin=%b busy=%b want 0 0", finished, busy);
            end
        end
        run_perm(4'd8, 8, rand_state(), 1'b0, 1'b0);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        nrounds  = 4'd0;
        state_in = '0;
        intr_clr = 1'b0;
        test_reset();
        test_p12();
        test_p6();
        test_p8_identity();
        test_invalid_rounds();
        test_back_to_back();
        test_intr_coincident();
        test_abort();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, want completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
